// File: rtl/i2s_pkg.sv
// Shared defaults and channel encoding for the I2S capture path.
package i2s_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_WIDTH   = 6;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings bck/lrck/sdata into the clk domain and flags each bck rising edge.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arst,
    input  logic bck,
    input  logic lrck,
    input  logic sdata,
    output logic lrck_s,
    output logic sdata_s,
    output logic rise_s
);

    logic [SYNC_STAGES-1:0] bck_q;
    logic [SYNC_STAGES-1:0] lrck_q;
    logic [SYNC_STAGES-1:0] sdata_q;
    logic                   bck_prev_q;

    // Synchroniser chains; all three share the same depth so they stay aligned.
    always_ff @(posedge clk) begin
        if (arst) begin
            bck_q      <= {SYNC_STAGES{1'b0}};
            lrck_q     <= {SYNC_STAGES{1'b0}};
            sdata_q    <= {SYNC_STAGES{1'b0}};
            bck_prev_q <= 1'b0;
        end else begin
            bck_q      <= {bck_q[SYNC_STAGES-2:0], bck};
            lrck_q     <= {lrck_q[SYNC_STAGES-2:0], lrck};
            sdata_q    <= {sdata_q[SYNC_STAGES-2:0], sdata};
            bck_prev_q <= bck_q[SYNC_STAGES-1];
        end
    end

    assign lrck_s  = lrck_q[SYNC_STAGES-1];
    assign sdata_s = sdata_q[SYNC_STAGES-1];
    assign rise_s  = bck_q[SYNC_STAGES-1] & ~bck_prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deserialises externally clocked stereo frames into the clk domain.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left,
    output logic [DATA_WIDTH-1:0] right,
    output logic                  sample_valid,
    output logic                  short_slot,
    output logic                  locked
);

    localparam logic [CNT_WIDTH:0]   DW_W    = (CNT_WIDTH+1)'(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic lrck_s, sdata_s, rise_s;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .arst    (arst),
        .bck     (bck),
        .lrck    (lrck),
        .sdata   (sdata),
        .lrck_s  (lrck_s),
        .sdata_s (sdata_s),
        .rise_s  (rise_s)
    );

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, held_q, held_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  lrck_prev_q, lrck_prev_d, left_seen_q, left_seen_d;
    logic                  primed_q, primed_d, locked_q, locked_d;
    logic                  valid_q, valid_d, short_q, short_d;
    logic [CNT_WIDTH:0]    cnt_incl_s;
    logic                  room_s, is_short_s;
    logic [DATA_WIDTH-1:0] full_s, word_s;

    // One shift register suffices: the closing slot completes on the same rise that restarts it.
    always_comb begin
        cnt_incl_s = {1'b0, cnt_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
        room_s     = ({1'b0, cnt_q} < DW_W);
        is_short_s = (cnt_incl_s < DW_W);
        if (room_s) begin
            full_s = {shreg_q[DATA_WIDTH-2:0], sdata_s};
        end else begin
            full_s = shreg_q;
        end
        if (is_short_s) begin
            word_s = full_s << (DW_W - cnt_incl_s);
        end else begin
            word_s = full_s;
        end
    end

    // Next-state logic for the deserialiser and frame assembly.
    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        held_d      = held_q;
        left_d      = left_q;
        right_d     = right_q;
        lrck_prev_d = lrck_prev_q;
        left_seen_d = left_seen_q;
        primed_d    = primed_q;
        locked_d    = locked_q;
        valid_d     = 1'b0;
        short_d     = 1'b0;
        if (rise_s) begin
            lrck_prev_d = lrck_s;
            if (lrck_s != lrck_prev_q) begin
                cnt_d   = {CNT_WIDTH{1'b0}};
                shreg_d = {DATA_WIDTH{1'b0}};
                if (!primed_q) begin
                    // The slot in progress at reset is partial; drop it silently.
                    primed_d = 1'b1;
                end else begin
                    short_d = is_short_s;
                    if (lrck_prev_q == CH_LEFT) begin
                        held_d      = word_s;
                        left_seen_d = 1'b1;
                    end else if (left_seen_q && (lrck_prev_q == CH_RIGHT)) begin
                        left_d      = held_q;
                        right_d     = word_s;
                        valid_d     = 1'b1;
                        locked_d    = 1'b1;
                        left_seen_d = 1'b0;
                    end else begin
                        left_seen_d = left_seen_q;
                    end
                    if (is_short_s) begin
                        locked_d = 1'b0;
                    end else begin
                        locked_d = locked_d;
                    end
                end
            end else begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d = cnt_q;
                end
                shreg_d = full_s;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (arst) begin
            cnt_q       <= {CNT_WIDTH{1'b0}};
            shreg_q     <= {DATA_WIDTH{1'b0}};
            held_q      <= {DATA_WIDTH{1'b0}};
            left_q      <= {DATA_WIDTH{1'b0}};
            right_q     <= {DATA_WIDTH{1'b0}};
            lrck_prev_q <= 1'b0;
            left_seen_q <= 1'b0;
            primed_q    <= 1'b0;
            locked_q    <= 1'b0;
            valid_q     <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            held_q      <= held_d;
            left_q      <= left_d;
            right_q     <= right_d;
            lrck_prev_q <= lrck_prev_d;
            left_seen_q <= left_seen_d;
            primed_q    <= primed_d;
            locked_q    <= locked_d;
            valid_q     <= valid_d;
            short_q     <= short_d;
        end
    end

    assign left         = left_q;
    assign right        = right_q;
    assign sample_valid = valid_q;
    assign short_slot   = short_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed self-checking bench for i2s_receiver driving I2S frames at 8 clk per bck.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        arst, bck, lrck, sdata;
    logic [15:0] left, right;
    logic        sample_valid, short_slot, locked;

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int short_cnt = 0;
    int v0, s0;

    i2s_receiver dut (
        .clk          (clk),
        .arst         (arst),
        .bck          (bck),
        .lrck         (lrck),
        .sdata        (sdata),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .short_slot   (short_slot),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sample_valid) valid_cnt <= valid_cnt + 1;
        if (short_slot)   short_cnt <= short_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic lr, input logic d);
        bck   = 1'b0;
        lrck  = lr;
        sdata = d;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Bits of channel ch; the final bit is sent with lrck already switched, as I2S does.
    task automatic send_slot(input logic ch, input logic [31:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit((i == nbits - 1) ? ~ch : ch, data[nbits-1-i]);
        end
    endtask

    initial begin
        arst = 1'b1; bck = 1'b0; lrck = 1'b0; sdata = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left", {16'h0, left}, 32'h0);
        check("rst_right", {16'h0, right}, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_short", {31'h0, short_slot}, 32'h0);
        check("rst_locked", {31'h0, locked}, 32'h0);
        arst = 1'b0;
        repeat (4) @(negedge clk);

        // Start-up frame is discarded.
        send_slot(1'b0, 32'h0000_1234, 16);
        send_slot(1'b1, 32'h0000_ABCD, 16);
        check("startup_no_valid", valid_cnt, 32'd0);
        check("startup_locked", {31'h0, locked}, 32'h0);
        check("startup_no_short", short_cnt, 32'd0);

        send_slot(1'b0, 32'h0000_1234, 16);
        send_slot(1'b1, 32'h0000_ABCD, 16);
        check("f16_valid_cnt", valid_cnt, 32'd1);
        check("f16_left", {16'h0, left}, 32'h0000_1234);
        check("f16_right", {16'h0, right}, 32'h0000_ABCD);
        check("f16_locked", {31'h0, locked}, 32'h1);

        // 32-bit slots truncate to the top 16 bits.
        send_slot(1'b0, 32'h89AB_CDEF, 32);
        send_slot(1'b1, 32'h7654_3210, 32);
        check("f32_valid_cnt", valid_cnt, 32'd2);
        check("f32_left", {16'h0, left}, 32'h0000_89AB);
        check("f32_right", {16'h0, right}, 32'h0000_7654);
        check("f32_no_short", short_cnt, 32'd0);

        // Short left slot.
        send_slot(1'b0, 32'h0000_00A5, 8);
        check("short_cnt", short_cnt, 32'd1);
        check("short_unlocked", {31'h0, locked}, 32'h0);
        send_slot(1'b1, 32'h0000_5A5A, 16);
        check("short_valid_cnt", valid_cnt, 32'd3);
        check("short_left", {16'h0, left}, 32'h0000_A500);
        check("short_right", {16'h0, right}, 32'h0000_5A5A);
        check("short_relocked", {31'h0, locked}, 32'h1);
        check("short_once", short_cnt, 32'd1);

        // Negative samples pass bit-exact.
        send_slot(1'b0, 32'h0000_8000, 16);
        send_slot(1'b1, 32'h0000_FFFF, 16);
        check("neg_valid_cnt", valid_cnt, 32'd4);
        check("neg_left", {16'h0, left}, 32'h0000_8000);
        check("neg_right", {16'h0, right}, 32'h0000_FFFF);

        // Reset in the middle of a right slot.
        send_slot(1'b0, 32'h0000_1111, 16);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        check("mid_rst_left", {16'h0, left}, 32'h0);
        check("mid_rst_right", {16'h0, right}, 32'h0);
        check("mid_rst_locked", {31'h0, locked}, 32'h0);
        check("mid_rst_valid", {31'h0, sample_valid}, 32'h0);
        v0 = valid_cnt;
        for (int i = 0; i < 11; i++) send_bit((i == 10) ? 1'b0 : 1'b1, 1'b1);
        check("mid_rst_no_valid", valid_cnt, v0);
        send_slot(1'b0, 32'h0000_2222, 16);
        send_slot(1'b1, 32'h0000_3333, 16);
        check("post_rst_valid_cnt", valid_cnt, v0 + 1);
        check("post_rst_left", {16'h0, left}, 32'h0000_2222);
        check("post_rst_right", {16'h0, right}, 32'h0000_3333);
        check("post_rst_locked", {31'h0, locked}, 32'h1);

        // lrck stuck low for 200 bits: ones first, zeros after, to expose counter wrap.
        v0 = valid_cnt;
        s0 = short_cnt;
        for (int i = 0; i < 200; i++) send_bit(1'b0, (i < 16) ? 1'b1 : 1'b0);
        check("stuck_no_valid", valid_cnt, v0);
        check("stuck_left_hold", {16'h0, left}, 32'h0000_2222);
        check("stuck_right_hold", {16'h0, right}, 32'h0000_3333);
        send_bit(1'b1, 1'b0);
        send_slot(1'b1, 32'h0000_1357, 16);
        check("stuck_valid_cnt", valid_cnt, v0 + 1);
        check("stuck_long_left", {16'h0, left}, 32'h0000_FFFF);
        check("stuck_long_right", {16'h0, right}, 32'h0000_1357);
        check("stuck_no_short", short_cnt, s0);
        send_slot(1'b0, 32'h0000_4321, 16);
        send_slot(1'b1, 32'h0000_8765, 16);
        check("after_stuck_valid_cnt", valid_cnt, v0 + 2);
        check("after_stuck_left", {16'h0, left}, 32'h0000_4321);
        check("after_stuck_right", {16'h0, right}, 32'h0000_8765);
        check("after_stuck_locked", {31'h0, locked}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- I2S slave receiver; the capture-side counterpart of the PCM5102 transmitter path.
- Takes externally mastered bck, lrck and serial data from an ADC (e.g. PCM1808) and synchronises them into the 48 MHz clk domain.
- Deserialises MSB-first two's-complement samples and presents left/right words with a one-cycle valid strobe per stereo frame.
- Feeds the OPL3 mixer or loopback test path.

Parameters:
- DATA_WIDTH, 16: sample width delivered on left/right.
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).
- CNT_WIDTH, 6: slot bit-counter width; counter saturates at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock, 48 MHz.
- arst  input  1  reset, synchronous, active-high.
- bck  input  1  serial bit clock from external master, asynchronous to clk.
- lrck  input  1  word select from external master, asynchronous (0 = left, 1 = right).
- sdata  input  1  serial data from ADC, asynchronous.
- left  output  DATA_WIDTH  last completed left sample.
- right  output  DATA_WIDTH  last completed right sample.
- sample_valid  output  1  one-cycle pulse when left/right update.
- short_slot  output  1  one-cycle pulse when a completed slot held fewer than DATA_WIDTH bits.
- locked  output  1  high once a full left-then-right frame has been received.

Behaviour:
- Reset (arst high at a clk edge): left=0, right=0, sample_valid=0, short_slot=0, locked=0. Synchronisers, shift registers, counters, lrck_prev and the left-seen flag all clear. Reset mid-frame discards any partial data.
- Synchronisation: bck, lrck and sdata each pass through SYNC_STAGES flops. rise = bck_s & ~bck_s_d. All state updates only on clk edges where rise=1.
- Clocking requirement: clk ≥ 8× bck (3.072 MHz at 64 fs / 48 kHz is supported).
- Per rise event, sample L=lrck_s and D=sdata_s. Bit D belongs to channel lrck_prev, the lrck value at the previous rise. This implements the standard one-BCK delay.
  - If bit count < DATA_WIDTH: shift D into that channel's shift register, MSB first.
  - Otherwise: discard D. Wider slots are truncated and keep the top DATA_WIDTH bits.
  - The bit counter increments, saturating.
- Slot end: a rise with L != lrck_prev closes the slot of lrck_prev. The bit sampled at that rise is that slot's last bit and is included.
  - Count (including this bit) < DATA_WIDTH: word is left-aligned and zero-filled, and short_slot pulses.
  - Counter and the new channel's shift register restart at 0 on the following rise.
- Closing a left slot: latch it into a held-left register and set left-seen.
- Closing a right slot with left-seen=1:
  - left ← held-left; right ← completed right word; sample_valid=1 for exactly one clk; locked ← 1.
  - Both outputs update on the same edge.
  - Clear left-seen.
- Closing a right slot with left-seen=0: word is discarded and no valid pulse.
- Start-up: after reset, the first slot ends at the first observed lrck change and is partial, so it is discarded with no short_slot pulse. The first valid frame is therefore the first full left slot followed by the next right slot.
- short_slot also clears locked. locked re-asserts on the next valid frame.
- Latency: outputs update on the SYNC_STAGES-th clk edge after the edge that first samples bck high (SYNC_STAGES+1 edges counting the sampling edge).
- lrck stuck: no slot closes and outputs hold; the counter saturates and does not wrap.
- Data is passed through unmodified, with no sign manipulation.

Decomposition:
- Package i2s_pkg: DATA_WIDTH default, CNT_WIDTH, channel encoding constants CH_LEFT=0 and CH_RIGHT=1.
- One sub-module, i2s_sync_edge: parameterised SYNC_STAGES synchroniser for bck/lrck/sdata, plus the bck rise detector.
- The top handles the deserialiser and frame logic.

Test Plan:
- 32 fs, 16-bit slots, frames L=0x1234 R=0xABCD → first frame after reset discarded; next frame gives left=0x1234, right=0xABCD, one sample_valid pulse, locked=1.
- 64 fs, 32-bit slots L=0x89ABCDEF R=0x7654_3210 → left=0x89AB, right=0x7654, short_slot never pulses.
- Left slot of only 8 bits carrying 0xA5 → left=0xA500, short_slot pulses once, locked drops; next good frame re-asserts locked.
- Negative samples L=0x8000 R=0xFFFF → output bit-exact, with no sign change.
- arst asserted for 1 clk mid-right-slot → all outputs 0 next cycle; no valid for the interrupted frame; first valid follows the next full L→R pair.
- lrck held constant for 200 bck periods → no sample_valid, outputs unchanged; a valid frame afterwards decodes correctly.
